axi_mem_responder: RTL and testbench
====================================

AXI_MEM_RESPONDER -- requirements
Module: axi_mem_responder

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): DATA_W, 64, data bus width.
REQ-002 ADDR_W, 64, address width.
REQ-003 DEPTH, 1024, number of DATA_W-bit words.
REQ-004 BASE_ADDR, 64'h8000_0000, byte address of word 0.
REQ-005 The block SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-006 Ports (name, direction, width, meaning):
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- awvalid/awready  in/out  1/1  write-address handshake.
- awid  in  1  write ID; sampled, no effect on function.
- awaddr  in  ADDR_W  write byte address.
- wvalid/wready  in/out  1/1  write-data handshake.
- wdata  in  DATA_W  write data.
- wstrb  in  DATA_W/8  byte enables.
- bvalid/bready  out/in  1/1  write-response handshake.
- bresp  out  1  0=OKAY, 1=address error.
- arvalid/arready  in/out  1/1  read-address handshake.
- araddr  in  ADDR_W  read byte address.
- rvalid/rready  out/in  1/1  read-data handshake.
- rdata  out  DATA_W  read data.
- rresp  out  1  0=OKAY, 1=address error.

Function
REQ-007 A handshake on any channel SHALL occur on a rising clk edge where valid and ready are both 1.
REQ-008 Word index SHALL be (addr - BASE_ADDR) >> 3; addr[2:0] SHALL be ignored.
REQ-009 An address is in range iff BASE_ADDR <= addr < BASE_ADDR + DEPTH*8; the subtraction SHALL be ADDR_W wide with no wrap-around acceptance.
REQ-010 The write path SHALL be an FSM with states W_IDLE, W_WAIT, W_RESP.
REQ-011 In W_IDLE, awready=1 and wready=1. AW and W SHALL be accepted in the same cycle or in separate cycles, each latched into its own holding register with a held flag.
REQ-012 While an AW beat is held, awready SHALL be 0. While a W beat is held, wready SHALL be 0. W_WAIT means exactly one beat is held.
REQ-013 In the cycle both beats are available (latched or handshaking now), the write SHALL commit. It SHALL update only the bytes with wstrb[i]=1 when in range, and update nothing when out of range. The FSM SHALL then enter W_RESP.
REQ-014 In W_RESP: bvalid=1, awready=0, wready=0, bresp=in-range?0:1. bvalid and bresp SHALL hold stable until bready=1, then the FSM SHALL return to W_IDLE and clear the held flags.
REQ-015 The read path SHALL be an FSM with states R_IDLE and R_DATA, independent of the write path.
REQ-016 In R_IDLE, arready=1. On an AR handshake, the FSM SHALL register rdata (the word if in range, else 0) and rresp, then enter R_DATA. rvalid SHALL be 1 in the cycle immediately after the handshake.
REQ-017 In R_DATA: arready=0, rvalid=1, and rdata/rresp SHALL be stable until rready=1, then the FSM SHALL return to R_IDLE. A new AR SHALL be accepted no earlier than the following cycle.
REQ-018 If an AR handshake and a write commit target the same word in the same cycle, rdata SHALL return the pre-write value (read-before-write).
REQ-019 Exactly one outstanding write and one outstanding read SHALL be supported; there SHALL be no reordering or interleaving.

Reset
REQ-020 While rst=1: both FSMs SHALL go to idle, held flags SHALL clear, awready=0, wready=0, arready=0, bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0.
REQ-021 Ready signals SHALL rise in the first cycle after rst is deasserted.
REQ-022 Reset during any state SHALL discard in-flight beats and responses; a partially held write SHALL NOT commit.
REQ-023 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-024 Same-cycle AW+W: awaddr=0x8000_0010, wdata=0x1122334455667788, wstrb=0xFF, bready=1 -> bvalid=1 next cycle with bresp=0. A read of 0x8000_0010 then returns 0x1122334455667788 with rresp=0, and rvalid rises 1 cycle after AR.
REQ-025 Partial strobe: word holds 0xFFFF_FFFF_FFFF_FFFF; write wdata=0, wstrb=0x0F -> read returns 0xFFFF_FFFF_0000_0000.
REQ-026 W one cycle before AW -> wready=0 while held; commit on the AW handshake; one bvalid pulse only.
REQ-027 Out of range: write and read at 0x8000_2000 (DEPTH=1024) -> bresp=1, rresp=1, rdata=0, memory unchanged.
REQ-028 Backpressure: bready=0 and rready=0 for 5 cycles -> bvalid/rvalid, data and resp stable, arready=0, awready=0. Release -> one-cycle accept each, return to idle.
REQ-029 Reset mid-operation: AW accepted, rst=1 before W -> all valids/readies 0 during reset; a later W alone produces no write and no bvalid.

Source files
------------

// File: rtl/axi_mem_responder.sv
// Single-beat AXI-style memory responder: one outstanding write and one
// outstanding read, byte-strobed writes, range-checked addresses.
module axi_mem_responder #(
  parameter int          DATA_W    = 64,
  parameter int          ADDR_W    = 64,
  parameter int          DEPTH     = 1024,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                awvalid,
  output logic                awready,
  input  logic                awid,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic                wvalid,
  output logic                wready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic                bvalid,
  input  logic                bready,
  output logic                bresp,
  input  logic                arvalid,
  output logic                arready,
  input  logic [ADDR_W-1:0]   araddr,
  output logic                rvalid,
  input  logic                rready,
  output logic [DATA_W-1:0]   rdata,
  output logic                rresp,
  output logic [1:0]          wr_state_o,
  output logic                rd_state_o
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] BASE = BASE_ADDR[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] SPAN = ADDR_W'(DEPTH) << 3;

  // Handshake rule: a beat transfers on a rising clk edge where valid and
  // ready are both 1; every ready here depends only on state and rst.

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_WAIT = 2'd1, W_RESP = 2'd2} w_state_e;
  typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              aw_held_q, w_held_q;
  logic [ADDR_W-1:0] awaddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic              bresp_q;
  logic [DATA_W-1:0] rdata_q;
  logic              rresp_q;

  logic              aw_hs, w_hs, ar_hs, aw_avail, w_avail, commit;
  logic [ADDR_W-1:0] w_addr, w_off, r_off;
  logic [DATA_W-1:0] w_data;
  logic [STRB_W-1:0] w_strb;
  logic              w_in_range, r_in_range;
  logic [IDX_W-1:0]  w_idx, r_idx;
  logic              unused_bits;

  assign aw_hs    = awvalid && awready;
  assign w_hs     = wvalid && wready;
  assign ar_hs    = arvalid && arready;
  assign aw_avail = aw_held_q || aw_hs;
  assign w_avail  = w_held_q || w_hs;
  assign commit   = !rst && (w_state_q != W_RESP) && aw_avail && w_avail;

  assign w_addr = aw_held_q ? awaddr_q : awaddr;
  assign w_data = w_held_q ? wdata_q : wdata;
  assign w_strb = w_held_q ? wstrb_q : wstrb;

  // The lower-bound compare stops a wrapped subtraction from looking in range.
  assign w_off      = w_addr - BASE;
  assign r_off      = araddr - BASE;
  assign w_in_range = (w_addr >= BASE) && (w_off < SPAN);
  assign r_in_range = (araddr >= BASE) && (r_off < SPAN);
  assign w_idx      = w_off[IDX_W+2:3];
  assign r_idx      = r_off[IDX_W+2:3];

  assign unused_bits = ^{awid, w_off[2:0], r_off[2:0],
                         w_off[ADDR_W-1:IDX_W+3], r_off[ADDR_W-1:IDX_W+3]};

  // ---------------- write FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) w_state_q <= W_IDLE;
    else     w_state_q <= w_state_d;
  end

  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE, W_WAIT: begin
        if (commit)                  w_state_d = W_RESP;
        else if (aw_avail || w_avail) w_state_d = W_WAIT;
        else                         w_state_d = W_IDLE;
      end
      W_RESP:  if (bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    bresp   = 1'b0;
    if (!rst) begin
      case (w_state_q)
        W_IDLE, W_WAIT: begin
          awready = !aw_held_q;
          wready  = !w_held_q;
        end
        W_RESP: begin
          bvalid = 1'b1;
          bresp  = bresp_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      bresp_q   <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_held_q <= 1'b1;
        awaddr_q  <= awaddr;
      end
      if (w_hs) begin
        w_held_q <= 1'b1;
        wdata_q  <= wdata;
        wstrb_q  <= wstrb;
      end
      if (commit) bresp_q <= !w_in_range;
      if (w_state_q == W_RESP && bready) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
      end
    end
  end

  // Memory is never reset; only strobed bytes of an in-range word change.
  always_ff @(posedge clk) begin
    if (commit && w_in_range) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (w_strb[i]) mem[w_idx][i*8 +: 8] <= w_data[i*8 +: 8];
      end
    end
  end

  // ---------------- read FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) r_state_q <= R_IDLE;
    else     r_state_q <= r_state_d;
  end

  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (ar_hs)  r_state_d = R_DATA;
      R_DATA:  if (rready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    arready = 1'b0;
    rvalid  = 1'b0;
    rdata   = '0;
    rresp   = 1'b0;
    if (!rst) begin
      arready = (r_state_q == R_IDLE);
      rvalid  = (r_state_q == R_DATA);
      rdata   = rdata_q;
      rresp   = rresp_q;
    end
  end

  // Nonblocking read of mem gives the pre-write word on a same-cycle commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
      rresp_q <= 1'b0;
    end else if (ar_hs) begin
      rdata_q <= r_in_range ? mem[r_idx] : '0;
      rresp_q <= !r_in_range;
    end
  end

  assign wr_state_o = w_state_q;
  assign rd_state_o = (r_state_q == R_DATA);

endmodule

// File: tb/tb_axi_mem_responder.sv
// Bench for axi_mem_responder: directed corner cases plus randomized
// single-beat traffic checked against a word/byte memory model.
module tb_axi_mem_responder;

  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam int          DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        awvalid, awready, awid;
  logic [63:0] awaddr;
  logic        wvalid, wready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        bvalid, bready, bresp;
  logic        arvalid, arready;
  logic [63:0] araddr;
  logic        rvalid, rready;
  logic [63:0] rdata;
  logic        rresp;
  logic [1:0]  wr_state;
  logic        rd_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] model [int];

  axi_mem_responder dut (
    .clk(clk), .rst(rst),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .wr_state_o(wr_state), .rd_state_o(rd_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit in_rng(input logic [63:0] a);
    return (a >= BASE) && (a < BASE + 64'(DEPTH) * 8);
  endfunction

  function automatic int widx(input logic [63:0] a);
    return int'((a - BASE) >> 3);
  endfunction

  function automatic logic [63:0] waddr(input int idx);
    return BASE + 64'(idx) * 8;
  endfunction

  task automatic model_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
    logic [63:0] w;
    if (!in_rng(a)) return;
    w = model.exists(widx(a)) ? model[widx(a)] : 64'h0;
    for (int i = 0; i < 8; i++) if (s[i]) w[i*8 +: 8] = d[i*8 +: 8];
    model[widx(a)] = w;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // mode 0: AW+W together; 1: W first; 2: AW first. gap = idle cycles between.
  task automatic write_txn(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s,
                           input int mode, input int gap, input int stall);
    logic exp_resp;
    exp_resp = !in_rng(a);
    awaddr = a; wdata = d; wstrb = s; awid = 1'($urandom_range(0, 1));
    if (mode == 0) begin
      awvalid = 1'b1; wvalid = 1'b1;
      @(negedge clk);
      chk("aw_w_ready", {awready, wready}, 2'b11);
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
    end else begin
      if (mode == 1) wvalid = 1'b1; else awvalid = 1'b1;
      @(negedge clk);
      chk("first_ready", (mode == 1) ? wready : awready, 1'b1);
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      awaddr = $urandom(); wdata = {$urandom(), $urandom()}; wstrb = $urandom();
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        chk("held_ready", (mode == 1) ? wready : awready, 1'b0);
        chk("other_ready", (mode == 1) ? awready : wready, 1'b1);
        chk("held_no_bvalid", bvalid, 1'b0);
        tick();
      end
      if (mode == 1) begin awaddr = a; awvalid = 1'b1; end
      else begin wdata = d; wstrb = s; wvalid = 1'b1; end
      @(negedge clk);
      chk("second_ready", (mode == 1) ? awready : wready, 1'b1);
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
    end
    model_write(a, d, s);
    @(negedge clk);
    chk("bvalid", bvalid, 1'b1);
    chk("bresp", bresp, exp_resp);
    for (int k = 0; k < stall; k++) begin
      tick();
      @(negedge clk);
      chk("bvalid_hold", bvalid, 1'b1);
      chk("bresp_hold", bresp, exp_resp);
      chk("resp_aw_wready", {awready, wready}, 2'b00);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    @(negedge clk);
    chk("bvalid_drop", bvalid, 1'b0);
    chk("aw_ready_back", awready, 1'b1);
    tick();
  endtask

  task automatic read_txn(input logic [63:0] a, input int stall);
    logic [63:0] exp_d;
    bit known;
    known = !in_rng(a) || model.exists(widx(a));
    exp_d = !in_rng(a) ? 64'h0 : (model.exists(widx(a)) ? model[widx(a)] : 64'h0);
    araddr = a; arvalid = 1'b1;
    @(negedge clk);
    chk("arready", arready, 1'b1);
    tick();
    arvalid = 1'b0; araddr = $urandom();
    @(negedge clk);
    chk("rvalid", rvalid, 1'b1);
    if (known) chk("rdata", rdata, exp_d);
    chk("rresp", rresp, !in_rng(a));
    for (int k = 0; k < stall; k++) begin
      tick();
      @(negedge clk);
      chk("rvalid_hold", rvalid, 1'b1);
      if (known) chk("rdata_hold", rdata, exp_d);
      chk("rresp_hold", rresp, !in_rng(a));
      chk("arready_busy", arready, 1'b0);
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    @(negedge clk);
    chk("rvalid_drop", rvalid, 1'b0);
    chk("arready_back", arready, 1'b1);
    tick();
  endtask

  int pool [8] = '{0, 1, 2, 8, 100, 511, 1022, 1023};
  logic [63:0] bad [5];
  logic [63:0] old_v;

  initial begin
    bad[0] = BASE - 8;
    bad[1] = BASE + 64'(DEPTH) * 8;
    bad[2] = 64'h0;
    bad[3] = 64'hFFFF_FFFF_FFFF_FFF8;
    bad[4] = BASE + 64'(DEPTH) * 8 + 8;

    rst = 1'b1; awvalid = 0; awid = 0; awaddr = 0; wvalid = 0; wdata = 0; wstrb = 0;
    bready = 0; arvalid = 0; araddr = 0; rready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_readies", {awready, wready, arready}, 3'b000);
    chk("rst_valids", {bvalid, rvalid, bresp, rresp}, 4'b0000);
    chk("rst_rdata", rdata, 64'h0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_readies", {awready, wready, arready}, 3'b111);
    tick();

    // same-cycle write, bready already high, then readback
    bready = 1'b1;
    awaddr = BASE + 64'h10; wdata = 64'h1122334455667788; wstrb = 8'hFF;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    model_write(BASE + 64'h10, 64'h1122334455667788, 8'hFF);
    @(negedge clk);
    chk("direct_bvalid", bvalid, 1'b1);
    chk("direct_bresp", bresp, 1'b0);
    tick();
    bready = 1'b0;
    @(negedge clk);
    chk("direct_bvalid_once", bvalid, 1'b0);
    tick();
    read_txn(BASE + 64'h10, 0);

    // partial strobe
    write_txn(waddr(5), 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, 0, 0);
    write_txn(waddr(5), 64'h0, 8'h0F, 0, 0, 0);
    read_txn(waddr(5), 0);

    // W before AW, then AW before W
    write_txn(waddr(6), 64'hCAFE_F00D_DEAD_BEEF, 8'hFF, 1, 1, 0);
    read_txn(waddr(6), 0);
    write_txn(waddr(6) + 3, 64'h0123_4567_89AB_CDEF, 8'hA5, 2, 2, 1);
    read_txn(waddr(6), 1);

    // out of range aliasing onto word 0 must not touch it
    write_txn(waddr(0), 64'h5555_AAAA_5555_AAAA, 8'hFF, 0, 0, 0);
    write_txn(BASE + 64'h2000, 64'h1234_1234_1234_1234, 8'hFF, 0, 0, 0);
    read_txn(BASE + 64'h2000, 0);
    read_txn(waddr(0), 0);

    // initialise the random pool
    foreach (pool[i]) write_txn(waddr(pool[i]), {$urandom(), $urandom()}, 8'hFF, 0, 0, 0);

    // concurrent write + read to one word, 5 cycles of backpressure on both
    old_v = model[8];
    awaddr = waddr(8); wdata = ~old_v; wstrb = 8'hFF; araddr = waddr(8);
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    chk("rbw_rdata", rdata, old_v);
    for (int k = 0; k < 5; k++) begin
      tick();
      @(negedge clk);
      chk("bp_valids", {bvalid, rvalid}, 2'b11);
      chk("bp_readies", {awready, wready, arready}, 3'b000);
      chk("bp_rdata", rdata, old_v);
      chk("bp_resps", {bresp, rresp}, 2'b00);
    end
    bready = 1'b1; rready = 1'b1;
    tick();
    bready = 1'b0; rready = 1'b0;
    model_write(waddr(8), ~old_v, 8'hFF);
    @(negedge clk);
    chk("bp_release", {bvalid, rvalid, awready, wready, arready}, 5'b00111);
    tick();
    read_txn(waddr(8), 0);

    // reset between AW and W discards the held beat
    old_v = model[2];
    awaddr = waddr(2); awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_readies", {awready, wready, arready}, 3'b000);
    chk("mid_rst_valids", {bvalid, rvalid}, 2'b00);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_up", {awready, wready, arready}, 3'b111);
    wdata = ~old_v; wstrb = 8'hFF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("lone_w_no_b", bvalid, 1'b0);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    read_txn(waddr(2), 0);

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      logic [63:0] a;
      if ($urandom_range(0, 4) == 0) a = bad[$urandom_range(0, 4)] | 64'($urandom_range(0, 7));
      else a = waddr(pool[$urandom_range(0, 7)]) | 64'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0)
        write_txn(a, {$urandom(), $urandom()}, 8'($urandom()), $urandom_range(0, 2),
                  $urandom_range(0, 3), $urandom_range(0, 3));
      else
        read_txn(a, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
